// File: rtl/freq_count_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : freq_count_stream_if
// Brief    : Valid/ready symbol stream carrying one symbol per beat plus an
//            end-of-frame marker.
// Revision : 1.0 - initial release
// ============================================================================
interface freq_count_stream_if #(
    parameter int SYM_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_sym;
    logic             in_last;

    // Producer side: drives beats, observes back-pressure.
    modport master (
        output in_valid,
        output in_sym,
        output in_last,
        input  in_ready
    );

    // Consumer side: samples beats, drives back-pressure.
    modport slave (
        input  in_valid,
        input  in_sym,
        input  in_last,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/freq_count_stream.sv
`default_nettype none
// ============================================================================
// Module   : freq_count_stream
// Brief    : Per-symbol saturating frequency counter over a valid/ready
//            stream, with frame start/last/abort, out-of-range tally and a
//            frame length limit. Publishes packed {count, index} entries.
// Revision : 1.0 - initial release
// ============================================================================
module freq_count_stream #(
    parameter int SYM_W   = 4,
    parameter int NUM_SYM = 10,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = 5,
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               start,
    input  logic                               abort,
    freq_count_stream_if.slave                 stream,
    output logic [NUM_SYM*(CNT_W+IDX_W)-1:0]   freq_out,
    output logic [LEN_W-1:0]                   total_cnt,
    output logic [LEN_W-1:0]                   invalid_cnt,
    output logic                               busy,
    output logic                               done,
    output logic                               freq_valid,
    output logic                               len_err
);

    localparam int               c_entry_w = CNT_W + IDX_W;
    // One extra bit so the range test also works when NUM_SYM == 2^SYM_W.
    localparam logic [SYM_W:0]   c_num_sym = (SYM_W+1)'(NUM_SYM);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [LEN_W-1:0] c_len_max = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt [NUM_SYM];
    logic [LEN_W-1:0] r_total;
    logic [LEN_W-1:0] r_invalid;
    logic             r_ready;
    logic             r_done;
    logic             r_freq_valid;
    logic             r_len_err;

    logic             w_accept;
    logic             w_sym_ok;
    logic [LEN_W-1:0] w_total_inc;
    logic             w_hit_max;

    assign w_accept    = stream.in_valid & r_ready;
    assign w_sym_ok    = ({1'b0, stream.in_sym} < c_num_sym);
    assign w_total_inc = r_total + LEN_W'(1);
    // total_cnt never exceeds MAX_LEN, so the increment cannot wrap.
    assign w_hit_max   = (w_total_inc == c_max_len);

    // Frame control FSM together with all counters and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_total      <= '0;
            r_invalid    <= '0;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_freq_valid <= 1'b0;
            r_len_err    <= 1'b0;
            for (int k = 0; k < NUM_SYM; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // start outranks abort here; abort only matters in COUNT.
                    if (start) begin
                        r_state      <= ST_COUNT;
                        r_ready      <= 1'b1;
                        r_total      <= '0;
                        r_invalid    <= '0;
                        r_freq_valid <= 1'b0;
                        r_len_err    <= 1'b0;
                        for (int k = 0; k < NUM_SYM; k++) begin
                            r_cnt[k] <= '0;
                        end
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        // Beat in the same cycle is dropped; counts freeze.
                        r_state      <= ST_IDLE;
                        r_ready      <= 1'b0;
                        r_freq_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_total <= w_total_inc;
                        if (w_sym_ok) begin
                            for (int k = 0; k < NUM_SYM; k++) begin
                                if ((stream.in_sym == SYM_W'(k)) &&
                                    (r_cnt[k] != c_cnt_max)) begin
                                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                                end
                            end
                        end else if (r_invalid != c_len_max) begin
                            r_invalid <= r_invalid + LEN_W'(1);
                        end
                        if (stream.in_last || w_hit_max) begin
                            r_state      <= ST_IDLE;
                            r_ready      <= 1'b0;
                            r_done       <= 1'b1;
                            r_freq_valid <= 1'b1;
                            // A last beat that also hits the limit is a
                            // clean finish, not a length error.
                            r_len_err    <= ~stream.in_last;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Each entry pairs the live count with its constant symbol index.
    for (genvar k = 0; k < NUM_SYM; k++) begin : g_pack
        assign freq_out[k*c_entry_w +: c_entry_w] = {r_cnt[k], IDX_W'(k)};
    end

    assign stream.in_ready = r_ready;
    assign total_cnt       = r_total;
    assign invalid_cnt     = r_invalid;
    assign busy            = (r_state == ST_COUNT);
    assign done            = r_done;
    assign freq_valid      = r_freq_valid;
    assign len_err         = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_freq_count_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_count_stream
// Brief    : Directed bench for freq_count_stream. Instance a uses default
//            parameters, instance b uses MAX_LEN=511; both share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_count_stream;

    localparam int E = 13;

    logic CLK = 1'b0;
    logic RST;
    logic start, abort;
    logic in_valid, in_last;
    logic [3:0] in_sym;

    logic [129:0] freq_a, freq_b;
    logic [8:0]   total_a, total_b, inv_a, inv_b;
    logic         busy_a, busy_b, done_a, done_b;
    logic         fv_a, fv_b, lerr_a, lerr_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ev [10];

    freq_count_stream_if #(.SYM_W(4)) if_a ();
    freq_count_stream_if #(.SYM_W(4)) if_b ();

    assign if_a.in_valid = in_valid;
    assign if_a.in_sym   = in_sym;
    assign if_a.in_last  = in_last;
    assign if_b.in_valid = in_valid;
    assign if_b.in_sym   = in_sym;
    assign if_b.in_last  = in_last;

    freq_count_stream dut_a (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .stream(if_a),
        .freq_out(freq_a), .total_cnt(total_a), .invalid_cnt(inv_a),
        .busy(busy_a), .done(done_a), .freq_valid(fv_a), .len_err(lerr_a)
    );

    freq_count_stream #(.MAX_LEN(511)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .stream(if_b),
        .freq_out(freq_b), .total_cnt(total_b), .invalid_cnt(inv_b),
        .busy(busy_b), .done(done_b), .freq_valid(fv_b), .len_err(lerr_b)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] cnt_a(input int k);
        return freq_a[k*E+5 +: 8];
    endfunction

    function automatic logic [7:0] cnt_b(input int k);
        return freq_b[k*E+5 +: 8];
    endfunction

    // Expected packed vector from the expected-count table ev.
    function automatic logic [129:0] pack_exp();
        logic [129:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) begin
            v[k*E +: E] = {ev[k], 5'(k)};
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [3:0] s, input logic l);
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_sym = 4'd0; in_last = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // Reset state
        for (int k = 0; k < 10; k++) ev[k] = 8'd0;
        check("rst_freq",  256'(freq_a), 256'(pack_exp()));
        check("rst_total", 256'(total_a), 256'(0));
        check("rst_inv",   256'(inv_a), 256'(0));
        check("rst_ready", 256'(if_a.in_ready), 256'(0));
        check("rst_busy",  256'(busy_a), 256'(0));
        check("rst_done",  256'(done_a), 256'(0));
        check("rst_fv",    256'(fv_a), 256'(0));
        check("rst_lerr",  256'(lerr_a), 256'(0));

        // Beats and abort while IDLE are ignored
        in_valid = 1'b1; in_sym = 4'd3; abort = 1'b1;
        tick(); tick();
        in_valid = 1'b0; abort = 1'b0;
        tick();
        check("idle_freq",  256'(freq_a), 256'(pack_exp()));
        check("idle_total", 256'(total_a), 256'(0));
        check("idle_ready", 256'(if_a.in_ready), 256'(0));
        check("idle_busy",  256'(busy_a), 256'(0));

        // Frame 0,1,1,9,3,9; start and abort together -> start wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t1_ready", 256'(if_a.in_ready), 256'(1));
        check("t1_busy",  256'(busy_a), 256'(1));
        beat(4'd0, 1'b0); beat(4'd1, 1'b0); beat(4'd1, 1'b0);
        beat(4'd9, 1'b0); beat(4'd3, 1'b0); beat(4'd9, 1'b1);
        ev = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
        check("t1_freq",   256'(freq_a), 256'(pack_exp()));
        check("t1_entry1", 256'(freq_a[25:13]), 256'({8'd2, 5'd1}));
        check("t1_total",  256'(total_a), 256'(6));
        check("t1_inv",    256'(inv_a), 256'(0));
        check("t1_done",   256'(done_a), 256'(1));
        check("t1_fv",     256'(fv_a), 256'(1));
        check("t1_lerr",   256'(lerr_a), 256'(0));
        check("t1_busy0",  256'(busy_a), 256'(0));
        check("t1_b_freq", 256'(freq_b), 256'(pack_exp()));
        tick();
        check("t1_done_1cyc", 256'(done_a), 256'(0));
        check("t1_fv_hold",   256'(fv_a), 256'(1));

        // Gapped valid: four beats of 5 with idle cycles between
        do_start();
        check("t2_fv_clr",  256'(fv_a), 256'(0));
        check("t2_tot_clr", 256'(total_a), 256'(0));
        beat(4'd5, 1'b0); tick();
        check("t2_gap_tot", 256'(total_a), 256'(1));
        beat(4'd5, 1'b0); tick();
        beat(4'd5, 1'b0); tick();
        beat(4'd5, 1'b1);
        check("t2_cnt5",  256'(cnt_a(5)), 256'(4));
        check("t2_cnt1",  256'(cnt_a(1)), 256'(0));
        check("t2_total", 256'(total_a), 256'(4));
        check("t2_done",  256'(done_a), 256'(1));

        // Saturation on b (limit 511); a ends at its 256-beat limit
        do_start();
        for (int i = 0; i < 300; i++) beat(4'd4, (i == 299));
        check("t3_b_cnt4",  256'(cnt_b(4)), 256'(255));
        check("t3_b_total", 256'(total_b), 256'(300));
        check("t3_b_lerr",  256'(lerr_b), 256'(0));
        check("t3_b_done",  256'(done_b), 256'(1));
        check("t3_a_total", 256'(total_a), 256'(256));
        check("t3_a_lerr",  256'(lerr_a), 256'(1));
        check("t3_a_cnt4",  256'(cnt_a(4)), 256'(255));

        // Out-of-range symbols
        do_start();
        beat(4'd10, 1'b0); beat(4'd15, 1'b0); beat(4'd2, 1'b0); beat(4'd12, 1'b1);
        check("t4_inv",   256'(inv_a), 256'(3));
        check("t4_cnt2",  256'(cnt_a(2)), 256'(1));
        check("t4_total", 256'(total_a), 256'(4));
        check("t4_b_inv", 256'(inv_b), 256'(3));

        // Length limit without last
        do_start();
        for (int i = 0; i < 256; i++) beat(4'd7, 1'b0);
        check("t5_done",  256'(done_a), 256'(1));
        check("t5_lerr",  256'(lerr_a), 256'(1));
        check("t5_cnt7",  256'(cnt_a(7)), 256'(255));
        check("t5_total", 256'(total_a), 256'(256));
        check("t5_fv",    256'(fv_a), 256'(1));
        tick();
        check("t5_ready0", 256'(if_a.in_ready), 256'(0));
        check("t5_done0",  256'(done_a), 256'(0));
        check("t5_b_busy", 256'(busy_b), 256'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_b_abort", 256'(busy_b), 256'(0));
        check("t5_a_fv",    256'(fv_a), 256'(1));
        check("t5_a_lerr",  256'(lerr_a), 256'(1));

        // Length limit coinciding with last -> no length error
        do_start();
        for (int i = 0; i < 256; i++) beat(4'd7, (i == 255));
        check("t5b_done",   256'(done_a), 256'(1));
        check("t5b_lerr",   256'(lerr_a), 256'(0));
        check("t5b_cnt7",   256'(cnt_a(7)), 256'(255));
        check("t5b_b_lerr", 256'(lerr_b), 256'(0));

        // Abort after 3 beats, with a concurrent beat that must be dropped
        do_start();
        beat(4'd2, 1'b0); beat(4'd2, 1'b0); beat(4'd2, 1'b0);
        in_valid = 1'b1; in_sym = 4'd2; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        check("t6_done",  256'(done_a), 256'(0));
        check("t6_fv",    256'(fv_a), 256'(0));
        check("t6_busy",  256'(busy_a), 256'(0));
        check("t6_ready", 256'(if_a.in_ready), 256'(0));
        check("t6_total", 256'(total_a), 256'(3));
        check("t6_cnt2",  256'(cnt_a(2)), 256'(3));
        tick();
        check("t6_done_late", 256'(done_a), 256'(0));
        do_start();
        check("t6_clr_cnt2",  256'(cnt_a(2)), 256'(0));
        check("t6_clr_total", 256'(total_a), 256'(0));

        // Reset mid-frame
        beat(4'd1, 1'b0); beat(4'd1, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t7_total", 256'(total_a), 256'(0));
        check("t7_cnt1",  256'(cnt_a(1)), 256'(0));
        check("t7_busy",  256'(busy_a), 256'(0));
        check("t7_ready", 256'(if_a.in_ready), 256'(0));
        check("t7_done",  256'(done_a), 256'(0));
        check("t7_fv",    256'(fv_a), 256'(0));
        do_start();
        beat(4'd8, 1'b0); beat(4'd8, 1'b1);
        check("t7_cnt8",  256'(cnt_a(8)), 256'(2));
        check("t7_tot2",  256'(total_a), 256'(2));
        check("t7_done2", 256'(done_a), 256'(1));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/freq_count_stream.md
Name: freq_count_stream

Overview:
Parametrised symbol-frequency counter feeding the Huffman tree builder. It accepts a frame of symbols over a valid/ready stream, one symbol per beat. It keeps a saturating count per symbol and publishes a packed {count, index} vector. Additions over a fixed-width counter: configurable alphabet and widths, explicit frame start/last/abort, an out-of-range symbol tally, and a frame length limit with an error flag.

Parameters:
SYM_W, 4, symbol width in bits
NUM_SYM, 10, number of counted symbols (codes 0..NUM_SYM-1); 1 <= NUM_SYM <= 2^SYM_W
CNT_W, 8, per-symbol counter width (saturating)
IDX_W, 5, index field width in each packed entry; must be >= clog2(NUM_SYM)
MAX_LEN, 256, maximum beats per frame; 1 <= MAX_LEN <= 2^LEN_W-1
LEN_W, 9, width of the frame-length and invalid counters

Ports:
CLK  in  1  clock; all logic is on the rising edge
RST  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; starts a new frame (honoured only in IDLE)
abort  in  1  ends the current frame without a result (honoured only in COUNT)
in_valid  in  1  symbol beat valid
in_ready  out  1  block can accept a beat (high only in COUNT)
in_sym  in  SYM_W  symbol code
in_last  in  1  marks the final beat of the frame
freq_out  out  NUM_SYM*(CNT_W+IDX_W)  packed counts; entry k = bits [(k+1)E-1 : kE], E=CNT_W+IDX_W, entry = {count_k, k[IDX_W-1:0]}
total_cnt  out  LEN_W  beats accepted in the current/last frame
invalid_cnt  out  LEN_W  accepted beats with in_sym >= NUM_SYM
busy  out  1  high in COUNT
done  out  1  one-cycle pulse on normal or length-limited completion
freq_valid  out  1  freq_out holds a completed frame
len_err  out  1  last frame was terminated by MAX_LEN, not by in_last

Behaviour:
- Reset values: state IDLE. All counts, total_cnt and invalid_cnt = 0. in_ready, busy, done, freq_valid and len_err = 0. The index fields of freq_out are constants and are never reset-dependent.
- FSM states: IDLE and COUNT.
- IDLE with start=1: all counts, total_cnt, invalid_cnt, freq_valid and len_err are cleared, and the state moves to COUNT on the next edge. in_ready rises in the cycle after start.
- IDLE otherwise: outputs hold their values. in_valid is ignored, and abort is ignored.
- COUNT: in_ready=1. A beat is accepted when in_valid&in_ready.
- On an accepted beat, at the same edge:
  - total_cnt increments.
  - If in_sym < NUM_SYM, count[in_sym] increments, saturating at 2^CNT_W-1.
  - Otherwise invalid_cnt increments, saturating.
- Latency: an accepted beat is visible on freq_out one cycle later (registered). There is no internal buffering, and idle cycles with in_valid=0 change nothing.
- Termination: the frame ends on an accepted beat with in_last=1, or on the accepted beat that makes total_cnt == MAX_LEN, whichever comes first.
  - On termination the FSM returns to IDLE at that edge, done=1 for exactly one cycle, and freq_valid=1 (held until the next start or RST).
  - len_err=1 only if MAX_LEN was reached without in_last. If both happen on the same beat, len_err=0.
- abort in COUNT: return to IDLE next edge, no done pulse, freq_valid=0, counts left frozen. An accepted beat in the same cycle as abort is discarded (abort has priority).
- start in COUNT is ignored. start and abort in the same IDLE cycle: start wins.
- RST asserted mid-frame: everything returns to reset values at the next edge. Partial counts are lost and no done pulse is produced.
- Counter arithmetic is unsigned and never wraps. Counts saturate independently of total_cnt.

Test Plan:
- Defaults. start, then beats 0,1,1,9,3,9 (last on the 6th) -> count0=1, count1=2, count3=1, count9=2, others 0. total_cnt=6, invalid_cnt=0, done pulse one cycle after the 6th beat, freq_valid=1, entry1 = {8'd2,5'd1} (bits [25:13]).
- in_valid toggled 1/0 every other cycle while sending 4 beats of symbol 5 (last on the 4th) -> count5=4, total_cnt=4. in_valid pulses in IDLE before start leave all counts 0 and in_ready=0.
- Saturation with MAX_LEN=511. 300 beats of symbol 4, last on the 300th -> count4=255, total_cnt=300, len_err=0.
- Invalid symbols: beats 10,15,2,12, last -> invalid_cnt=3, count2=1, total_cnt=4.
- Length limit: 256 beats of symbol 7 with in_last=0 -> done pulse after the 256th beat, len_err=1, count7=255, in_ready=0 afterwards. Repeat with in_last=1 on beat 256 -> len_err=0.
- abort after 3 beats -> no done pulse, freq_valid=0, busy=0. A new start then clears counts. Separately, RST high after 2 beats -> all outputs 0 next cycle. A following frame 8,8 with last -> count8=2.
